switch_mcast_top: RTL and testbench
===================================

Name: switch_mcast_top

Overview:
Parametrised N-port packet switch, next generation of the single-destination switch: per-port destination-address match, plus multicast/broadcast replication of one input packet into several output FIFOs.
Contains one input parser FSM, NUM_OF_PORTS output FIFOs and a memory-mapped config/status register file.
Adds a drop path for unroutable packets, a saturating drop counter and per-port fill-level readback.

Parameters:
NUM_OF_PORTS, 4, number of output ports (1..8)
FIFO_DEPTH, 16, words per output FIFO; power of 2, >=4
WORD_WIDTH, 8, data/address/register width in bits
BCAST_ADDR, {WORD_WIDTH{1'b1}}, destination address meaning "all ports"

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
sw_enable_in  in  1  high for every word of a packet; low between packets
data_in  in  WORD_WIDTH  packet word; first word of packet = destination address (DA)
read_out  out  1  input ready; word transferred when sw_enable_in & read_out
port_out  out  NUM_OF_PORTS*WORD_WIDTH  FIFO head words, port i at bits [i*W +: W]
port_ready  out  NUM_OF_PORTS  FIFO i non-empty
port_read  in  NUM_OF_PORTS  pop FIFO i
mem_sel_en  in  1  register access request
mem_wr_rd_s  in  1  1 = write, 0 = read
mem_addr  in  WORD_WIDTH  register address
mem_wr_data  in  WORD_WIDTH  write data
mem_rd_data  out  WORD_WIDTH  read data, valid with mem_ack
mem_ack  out  1  one-cycle access acknowledge

Behaviour:
- Reset (async, rst=1): FSM IDLE; all FIFOs empty; port_ready=0; port_out=0; read_out=0 while rst high; mem_ack=0; mem_rd_data=0; PORT_ADDR[i]=i; CTRL=1; DROP_CNT=0.
- Register map: 0..N-1 PORT_ADDR[i] RW; N CTRL RW (bit0 bcast_en, other bits read 0); N+1 DROP_CNT RO, saturates at all-ones, write of any value clears it; N+2+i FILL[i] RO (FIFO i occupancy, 0..FIFO_DEPTH); unmapped: reads 0, writes ignored.
- Register access: mem_sel_en sampled at edge k -> mem_ack=1 and mem_rd_data valid for cycle k+1 only; write takes effect at edge k. mem_sel_en held high = one access per 2 cycles (no ack in cycle after ack). mem_rd_data=0 when mem_ack=0.
- Route mask (from a DA word): bit i = (DA==PORT_ADDR[i]) | (bcast_en & DA==BCAST_ADDR). Duplicate PORT_ADDR values are legal -> multicast.
- FSM IDLE: read_out = !(|(mask(data_in) & full)).
  - sw_enable_in=1, mask nonzero, read_out=1: write DA to every masked FIFO, latch mask_q, -> FWD.
  - sw_enable_in=1, mask zero: read_out=1, word consumed, DROP_CNT+1 (saturating), -> DROP.
  - Masked FIFO full: read_out=0, stay IDLE; DA retried next cycle.
- FWD: read_out = !(|(mask_q & full)); on transfer write word to all mask_q FIFOs in the same cycle (all-or-nothing, never partial). sw_enable_in=0 -> IDLE (no write).
- DROP: read_out=1; words discarded; sw_enable_in=0 -> IDLE.
- Config writes during FWD/DROP affect next packet only; mask_q is fixed per packet.
- full uses registered count; a pop in same cycle does not raise read_out that cycle (conservative, 1-cycle bubble).
- Output: first-word-fall-through; port_out[i] = head of FIFO i whenever port_ready[i], else 0. port_read[i] with FIFO empty ignored. Push and pop on same FIFO same cycle: count unchanged, both take effect. Pointers wrap mod FIFO_DEPTH.
- Reset mid-packet: FIFOs flushed, partial packet lost; remainder of packet arriving after reset release while sw_enable_in high is treated as new packet (first word = DA).
- Latency: input word accepted at edge k -> visible on port_out / port_ready=1 in cycle k+1.

Test Plan:
- Reset defaults: after rst pulse read addr 0..3 -> 0,1,2,3; addr 4 -> 1; addr 5 -> 0; mem_ack exactly 1 cycle after each request.
- Unicast: packet {8'h02,8'hA1,8'hA2} -> only port 2: port_ready[2]=1 one cycle after DA; pops give 02,A1,A2; FILL[2] reads 3 then 0.
- Multicast: write PORT_ADDR[1]=PORT_ADDR[3]=8'h10; send {10,55} -> ports 1 and 3 each hold {10,55}; ports 0,2 empty.
- Broadcast: DA=8'hFF with bcast_en=1 -> all 4 FIFOs get packet; write CTRL=0, resend -> dropped, DROP_CNT=1, read_out high throughout.
- Backpressure: fill port 0 to 16 words, no reads; send 3-word packet to ports 0,1 -> read_out=0, neither FIFO written; pop port 0 once -> read_out=1 one cycle later, both FIFOs receive DA.
- Drop saturation/clear: 300 unroutable packets (W=8) -> DROP_CNT=255; write addr 5 -> DROP_CNT=0.

Source files
------------

// File: rtl/switch_mcast_top.sv
// switch_mcast_top: N-port packet switch with per-port destination-address match,
// multicast/broadcast replication into output FIFOs, a drop path for unroutable
// packets and a memory-mapped config/status register file.

module switch_mcast_top #(
    parameter int unsigned           NUM_OF_PORTS = 4,
    parameter int unsigned           FIFO_DEPTH   = 16,
    parameter int unsigned           WORD_WIDTH   = 8,
    parameter logic [WORD_WIDTH-1:0] BCAST_ADDR   = {WORD_WIDTH{1'b1}}
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               sw_enable_in,
    input  logic [WORD_WIDTH-1:0]              data_in,
    output logic                               read_out,
    output logic [NUM_OF_PORTS*WORD_WIDTH-1:0] port_out,
    output logic [NUM_OF_PORTS-1:0]            port_ready,
    input  logic [NUM_OF_PORTS-1:0]            port_read,
    input  logic                               mem_sel_en,
    input  logic                               mem_wr_rd_s,
    input  logic [WORD_WIDTH-1:0]              mem_addr,
    input  logic [WORD_WIDTH-1:0]              mem_wr_data,
    output logic [WORD_WIDTH-1:0]              mem_rd_data,
    output logic                               mem_ack
);

    localparam int unsigned N     = NUM_OF_PORTS;
    localparam int unsigned W     = WORD_WIDTH;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [W-1:0]     CTRL_ADDR = W'(N);
    localparam logic [W-1:0]     DROP_ADDR = W'(N + 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    // parser state
    state_e         state_q, state_d;
    logic [N-1:0]   mask_q, mask_d;

    // output FIFOs
    logic [W-1:0]     mem_q    [N][FIFO_DEPTH];
    logic [W-1:0]     mem_d    [N][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [N];
    logic [PTR_W-1:0] wr_ptr_d [N];
    logic [PTR_W-1:0] rd_ptr_q [N];
    logic [PTR_W-1:0] rd_ptr_d [N];
    logic [CNT_W-1:0] cnt_q    [N];
    logic [CNT_W-1:0] cnt_d    [N];

    // register file
    logic [W-1:0] port_addr_q [N];
    logic [W-1:0] port_addr_d [N];
    logic         bcast_en_q, bcast_en_d;
    logic [W-1:0] drop_cnt_q, drop_cnt_d;
    logic         ack_q, ack_d;
    logic [W-1:0] rd_data_q, rd_data_d;

    // combinational helpers
    logic [N-1:0] full_c;
    logic [N-1:0] in_mask_c;
    logic [N-1:0] push_c;
    logic [N-1:0] pop_c;
    logic         drop_inc_c;
    logic         ro_c;
    logic         acc_c;
    logic [W-1:0] reg_rdata_c;

    // Route mask of the incoming word and per-FIFO full flags (registered count).
    always_comb begin
        full_c    = '0;
        in_mask_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            full_c[i]    = (cnt_q[i] == CNT_FULL);
            in_mask_c[i] = (data_in == port_addr_q[i]) |
                           (bcast_en_q & (data_in == BCAST_ADDR));
        end
    end

    // Parser next-state: latch route mask on DA, replicate words, or discard.
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        push_c     = '0;
        drop_inc_c = 1'b0;
        ro_c       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ro_c = ~|(in_mask_c & full_c);
                if (sw_enable_in) begin
                    if (in_mask_c == '0) begin
                        drop_inc_c = 1'b1;
                        state_d    = ST_DROP;
                    end else if (ro_c) begin
                        push_c  = in_mask_c;
                        mask_d  = in_mask_c;
                        state_d = ST_FWD;
                    end
                end
            end
            ST_FWD: begin
                ro_c = ~|(mask_q & full_c);
                if (!sw_enable_in) begin
                    state_d = ST_IDLE;
                end else if (ro_c) begin
                    push_c = mask_q;
                end
            end
            ST_DROP: begin
                ro_c = 1'b1;
                if (!sw_enable_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign read_out = ro_c & ~rst;

    // Parser state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
        end
    end

    // FIFO next-state: all-or-nothing push of data_in, pop ignored when empty.
    always_comb begin
        mem_d = mem_q;
        pop_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pop_c[i]    = port_read[i] & (cnt_q[i] != '0);
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            if (push_c[i]) begin
                mem_d[i][wr_ptr_q[i]] = data_in;
                wr_ptr_d[i]           = wr_ptr_q[i] + PTR_W'(1);
            end
            if (pop_c[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
            end
            cnt_d[i] = cnt_q[i] + CNT_W'(push_c[i]) - CNT_W'(pop_c[i]);
        end
    end

    // FIFO storage; contents need no reset since reads are gated by the count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // FIFO pointers and occupancy counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // First-word-fall-through heads; zero while a FIFO is empty.
    always_comb begin
        port_out   = '0;
        port_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            port_ready[i] = (cnt_q[i] != '0);
            if (cnt_q[i] != '0) begin
                port_out[i*W +: W] = mem_q[i][rd_ptr_q[i]];
            end
        end
    end

    // Register read mux; unmapped addresses read as zero.
    always_comb begin
        reg_rdata_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (mem_addr == W'(i)) begin
                reg_rdata_c = port_addr_q[i];
            end
            if (mem_addr == W'(N + 2 + i)) begin
                reg_rdata_c = W'(cnt_q[i]);
            end
        end
        if (mem_addr == CTRL_ADDR) begin
            reg_rdata_c = W'(bcast_en_q);
        end
        if (mem_addr == DROP_ADDR) begin
            reg_rdata_c = drop_cnt_q;
        end
    end

    // Register next-state: one access per two cycles, write clears drop counter.
    always_comb begin
        port_addr_d = port_addr_q;
        bcast_en_d  = bcast_en_q;
        drop_cnt_d  = drop_cnt_q;
        acc_c       = mem_sel_en & ~ack_q;
        ack_d       = acc_c;
        rd_data_d   = '0;
        if (drop_inc_c && (drop_cnt_q != {W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + W'(1);
        end
        if (acc_c) begin
            if (mem_wr_rd_s) begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (mem_addr == W'(i)) begin
                        port_addr_d[i] = mem_wr_data;
                    end
                end
                if (mem_addr == CTRL_ADDR) begin
                    bcast_en_d = mem_wr_data[0];
                end
                if (mem_addr == DROP_ADDR) begin
                    drop_cnt_d = '0;
                end
            end else begin
                rd_data_d = reg_rdata_c;
            end
        end
    end

    // Register file and access-response flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N; i++) begin
                port_addr_q[i] <= W'(i);
            end
            bcast_en_q <= 1'b1;
            drop_cnt_q <= '0;
            ack_q      <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            port_addr_q <= port_addr_d;
            bcast_en_q  <= bcast_en_d;
            drop_cnt_q  <= drop_cnt_d;
            ack_q       <= ack_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign mem_ack     = ack_q;
    assign mem_rd_data = rd_data_q;

endmodule

// File: tb/tb_switch_mcast_top.sv
// Testbench for switch_mcast_top: directed scenarios plus randomized packets,
// checked against a queue-based reference model of the switch.

module tb_switch_mcast_top;

    localparam int N = 4;
    localparam int D = 16;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           sw_enable_in;
    logic [W-1:0]   data_in;
    logic           read_out;
    logic [N*W-1:0] port_out;
    logic [N-1:0]   port_ready;
    logic [N-1:0]   port_read;
    logic           mem_sel_en;
    logic           mem_wr_rd_s;
    logic [W-1:0]   mem_addr;
    logic [W-1:0]   mem_wr_data;
    logic [W-1:0]   mem_rd_data;
    logic           mem_ack;

    switch_mcast_top #(
        .NUM_OF_PORTS(N),
        .FIFO_DEPTH  (D),
        .WORD_WIDTH  (W),
        .BCAST_ADDR  (8'hFF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sw_enable_in(sw_enable_in),
        .data_in     (data_in),
        .read_out    (read_out),
        .port_out    (port_out),
        .port_ready  (port_ready),
        .port_read   (port_read),
        .mem_sel_en  (mem_sel_en),
        .mem_wr_rd_s (mem_wr_rd_s),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .mem_ack     (mem_ack)
    );

    always #5 clk = ~clk;

    // reference model
    logic [W-1:0] m_q [N][$];
    logic [W-1:0] m_addr [N];
    bit           m_bcast;
    int           m_drop;
    bit           m_in_pkt;
    bit           m_dropping;
    logic [N-1:0] m_pkt_mask;
    bit           m_xfer;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] pkt [32];

    function automatic logic [N-1:0] route(input logic [W-1:0] da);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (da == m_addr[i]) || (m_bcast && da == 8'hFF);
        return r;
    endfunction

    function automatic logic [N-1:0] m_full();
        logic [N-1:0] f;
        for (int i = 0; i < N; i++) f[i] = (m_q[i].size() == D);
        return f;
    endfunction

    function automatic logic [N-1:0] m_nonempty();
        logic [N-1:0] f;
        for (int i = 0; i < N; i++) f[i] = (m_q[i].size() > 0);
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_q[i].delete();
            m_addr[i] = W'(i);
        end
        m_bcast    = 1'b1;
        m_drop     = 0;
        m_in_pkt   = 1'b0;
        m_dropping = 1'b0;
        m_pkt_mask = '0;
    endtask

    // One packet-side clock cycle: drive, check read_out, advance model, check outputs.
    task automatic tick(input logic en, input logic [W-1:0] d, input logic [N-1:0] rd);
        logic [N-1:0] mk;
        logic [N-1:0] pops;
        logic         exp_ro;
        logic [W-1:0] exp_out;
        sw_enable_in = en;
        data_in      = d;
        port_read    = rd;
        mem_sel_en   = 1'b0;
        #1;
        if (!m_in_pkt) begin
            mk     = route(d);
            exp_ro = !(|(mk & m_full()));
        end else if (m_dropping) begin
            mk     = '0;
            exp_ro = 1'b1;
        end else begin
            mk     = m_pkt_mask;
            exp_ro = !(|(mk & m_full()));
        end
        vectors++;
        if (read_out !== exp_ro) begin
            miscompares++;
            $display("FAIL read_out: got %b expected %b (en=%b data=%h t=%0t)", read_out, exp_ro, en, d, $time);
        end
        m_xfer = en && exp_ro;
        @(posedge clk);
        for (int i = 0; i < N; i++) pops[i] = rd[i] && (m_q[i].size() > 0);
        for (int i = 0; i < N; i++) if (pops[i]) void'(m_q[i].pop_front());
        if (en) begin
            if (exp_ro) begin
                if (!m_in_pkt) begin
                    m_in_pkt = 1'b1;
                    if (mk == '0) begin
                        m_dropping = 1'b1;
                        if (m_drop < 255) m_drop++;
                    end else begin
                        m_pkt_mask = mk;
                    end
                end
                if (!m_dropping)
                    for (int i = 0; i < N; i++) if (m_pkt_mask[i]) m_q[i].push_back(d);
            end
        end else begin
            m_in_pkt   = 1'b0;
            m_dropping = 1'b0;
        end
        #1;
        for (int i = 0; i < N; i++) begin
            exp_out = (m_q[i].size() > 0) ? m_q[i][0] : 8'h00;
            vectors++;
            if (port_ready[i] !== (m_q[i].size() > 0)) begin
                miscompares++;
                $display("FAIL port_ready[%0d]: got %b expected %b (t=%0t)", i, port_ready[i], m_q[i].size() > 0, $time);
            end
            vectors++;
            if (port_out[i*W +: W] !== exp_out) begin
                miscompares++;
                $display("FAIL port_out[%0d]: got %h expected %h (t=%0t)", i, port_out[i*W +: W], exp_out, $time);
            end
        end
    endtask

    task automatic send_pkt(input int len, input bit rnd);
        int tries;
        for (int k = 0; k < len; k++) begin
            tries = 0;
            do begin
                tick(1'b1, pkt[k], rnd ? N'($urandom_range(0, 15)) : '0);
                tries++;
            end while (!m_xfer && tries < 100);
            vectors++;
            if (!m_xfer) begin
                miscompares++;
                $display("FAIL send_timeout: word %0d never accepted, got read_out %b expected 1", k, read_out);
            end
        end
        tick(1'b0, 8'h00, '0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (m_nonempty() != '0 && guard < 64) begin
            tick(1'b0, 8'h00, m_nonempty());
            guard++;
        end
        vectors++;
        if (port_ready !== '0) begin
            miscompares++;
            $display("FAIL drain: port_ready got %b expected 0000", port_ready);
        end
    endtask

    task automatic reg_read(input logic [W-1:0] a, input logic [W-1:0] exp, input string nm);
        sw_enable_in = 1'b0;
        port_read    = '0;
        mem_sel_en   = 1'b1;
        mem_wr_rd_s  = 1'b0;
        mem_addr     = a;
        @(posedge clk);
        #1;
        mem_sel_en = 1'b0;
        m_in_pkt   = 1'b0;
        m_dropping = 1'b0;
        vectors++;
        if (mem_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL %s ack: got %b expected 1", nm, mem_ack);
        end
        vectors++;
        if (mem_rd_data !== exp) begin
            miscompares++;
            $display("FAIL %s data: got %h expected %h", nm, mem_rd_data, exp);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (mem_ack !== 1'b0 || mem_rd_data !== 8'h00) begin
            miscompares++;
            $display("FAIL %s idle: got ack %b data %h expected 0 00", nm, mem_ack, mem_rd_data);
        end
    endtask

    task automatic reg_write(input logic [W-1:0] a, input logic [W-1:0] d);
        sw_enable_in = 1'b0;
        port_read    = '0;
        mem_sel_en   = 1'b1;
        mem_wr_rd_s  = 1'b1;
        mem_addr     = a;
        mem_wr_data  = d;
        @(posedge clk);
        #1;
        mem_sel_en = 1'b0;
        m_in_pkt   = 1'b0;
        m_dropping = 1'b0;
        if (a < N) m_addr[a] = d;
        if (a == N) m_bcast = d[0];
        if (a == N + 1) m_drop = 0;
        vectors++;
        if (mem_ack !== 1'b1 || mem_rd_data !== 8'h00) begin
            miscompares++;
            $display("FAIL write_ack: got ack %b data %h expected 1 00", mem_ack, mem_rd_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        sw_enable_in = 1'b1;
        data_in      = 8'h00;
        port_read    = '0;
        mem_sel_en   = 1'b0;
        mem_wr_rd_s  = 1'b0;
        mem_addr     = '0;
        mem_wr_data  = '0;
        #12;
        vectors++;
        if (read_out !== 1'b0 || port_ready !== '0 || port_out !== '0 || mem_ack !== 1'b0 || mem_rd_data !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ro %b rdy %b out %h ack %b rd %h expected all 0",
                     read_out, port_ready, port_out, mem_ack, mem_rd_data);
        end
        sw_enable_in = 1'b0;
        #10;
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        for (int i = 0; i < N; i++) reg_read(W'(i), W'(i), "reset_port_addr");
        reg_read(8'd4, 8'd1, "reset_ctrl");
        reg_read(8'd5, 8'd0, "reset_drop_cnt");
        reg_read(8'd6, 8'd0, "reset_fill0");
        reg_read(8'd9, 8'd0, "reset_fill3");
        reg_read(8'd12, 8'd0, "unmapped_read");
    endtask

    task automatic test_back_to_back();
        logic exp_ack;
        mem_sel_en  = 1'b1;
        mem_wr_rd_s = 1'b0;
        mem_addr    = 8'd4;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            exp_ack = (c % 2 == 0);
            vectors++;
            if (mem_ack !== exp_ack || mem_rd_data !== (exp_ack ? 8'd1 : 8'd0)) begin
                miscompares++;
                $display("FAIL held_sel cycle %0d: got ack %b data %h expected %b %h",
                         c, mem_ack, mem_rd_data, exp_ack, exp_ack ? 8'd1 : 8'd0);
            end
        end
        mem_sel_en = 1'b0;
        @(posedge clk);
        #1;
        reg_write(8'd12, 8'h99);
        reg_read(8'd12, 8'd0, "unmapped_after_write");
    endtask

    task automatic test_unicast();
        tick(1'b1, 8'h02, '0);
        vectors++;
        if (port_ready !== 4'b0100 || port_out[23:16] !== 8'h02) begin
            miscompares++;
            $display("FAIL unicast_da: got rdy %b out2 %h expected 0100 02", port_ready, port_out[23:16]);
        end
        tick(1'b1, 8'hA1, '0);
        tick(1'b1, 8'hA2, '0);
        tick(1'b0, 8'h00, '0);
        reg_read(8'd8, 8'd3, "unicast_fill2_full");
        for (int k = 0; k < 3; k++) tick(1'b0, 8'h00, 4'b0100);
        reg_read(8'd8, 8'd0, "unicast_fill2_empty");
    endtask

    task automatic test_multicast();
        reg_write(8'd1, 8'h10);
        reg_write(8'd3, 8'h10);
        pkt[0] = 8'h10;
        pkt[1] = 8'h55;
        send_pkt(2, 1'b0);
        vectors++;
        if (port_ready !== 4'b1010 || port_out[15:8] !== 8'h10 || port_out[31:24] !== 8'h10) begin
            miscompares++;
            $display("FAIL multicast: got rdy %b out %h expected 1010 heads 10", port_ready, port_out);
        end
        reg_read(8'd7, 8'd2, "multicast_fill1");
        reg_read(8'd9, 8'd2, "multicast_fill3");
        drain();
    endtask

    task automatic test_broadcast_drop();
        pkt[0] = 8'hFF;
        pkt[1] = 8'hC1;
        pkt[2] = 8'hC2;
        send_pkt(3, 1'b0);
        vectors++;
        if (port_ready !== 4'b1111) begin
            miscompares++;
            $display("FAIL broadcast: got rdy %b expected 1111", port_ready);
        end
        drain();
        reg_write(8'd4, 8'h00);
        send_pkt(3, 1'b0);
        vectors++;
        if (port_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL bcast_disabled: got rdy %b expected 0000", port_ready);
        end
        reg_read(8'd5, 8'd1, "drop_cnt_one");
    endtask

    task automatic test_backpressure();
        int tries;
        reg_write(8'd1, 8'h20);
        pkt[0] = 8'h00;
        for (int k = 1; k < 16; k++) pkt[k] = W'($urandom_range(0, 255));
        send_pkt(16, 1'b0);
        reg_read(8'd6, 8'd16, "bp_fill0_full");
        reg_write(8'd1, 8'h00);
        tick(1'b1, 8'h00, '0);
        tick(1'b1, 8'h00, '0);
        vectors++;
        if (read_out !== 1'b0 || port_ready[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_stall: got ro %b rdy1 %b expected 0 0", read_out, port_ready[1]);
        end
        tick(1'b1, 8'h00, 4'b0001);
        #1;
        vectors++;
        if (read_out !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release: got ro %b expected 1", read_out);
        end
        tick(1'b1, 8'h00, '0);
        vectors++;
        if (port_ready[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_da_port1: got rdy1 %b expected 1", port_ready[1]);
        end
        for (int k = 0; k < 2; k++) begin
            tries = 0;
            do begin
                tick(1'b1, 8'hB1 + W'(k), (m_q[0].size() == D) ? 4'b0001 : 4'b0000);
                tries++;
            end while (!m_xfer && tries < 10);
        end
        tick(1'b0, 8'h00, '0);
        reg_read(8'd7, 8'd3, "bp_fill1");
        drain();
    endtask

    task automatic test_drop_saturation();
        for (int k = 0; k < 300; k++) begin
            tick(1'b1, 8'h77, '0);
            tick(1'b0, 8'h00, '0);
        end
        reg_read(8'd5, 8'd255, "drop_saturated");
        reg_write(8'd5, 8'h5A);
        reg_read(8'd5, 8'd0, "drop_cleared");
    endtask

    task automatic test_reset_midpacket();
        tick(1'b1, 8'h02, '0);
        tick(1'b1, 8'hD1, '0);
        data_in = 8'h03;
        rst     = 1'b1;
        #2;
        vectors++;
        if (port_ready !== '0 || read_out !== 1'b0) begin
            miscompares++;
            $display("FAIL midpkt_reset: got rdy %b ro %b expected 0000 0", port_ready, read_out);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        tick(1'b1, 8'h03, '0);
        tick(1'b1, 8'hD3, '0);
        tick(1'b0, 8'h00, '0);
        vectors++;
        if (port_ready !== 4'b1000) begin
            miscompares++;
            $display("FAIL midpkt_new_da: got rdy %b expected 1000", port_ready);
        end
        reg_read(8'd4, 8'd1, "midpkt_ctrl_reset");
        drain();
    endtask

    task automatic test_random();
        int len;
        int r;
        int p;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                p = $urandom_range(0, 4);
                if (p < N) reg_write(W'(p), W'($urandom_range(0, 7)));
                else reg_write(8'd4, W'($urandom_range(0, 1)));
            end
            len = $urandom_range(1, 5);
            r   = $urandom_range(0, 9);
            if (r < 7)      pkt[0] = W'($urandom_range(0, 7));
            else if (r < 9) pkt[0] = 8'hFF;
            else            pkt[0] = W'($urandom_range(0, 255));
            for (int k = 1; k < len; k++) pkt[k] = W'($urandom_range(0, 255));
            send_pkt(len, 1'b1);
            p = $urandom_range(0, N - 1);
            reg_read(W'(6 + p), W'(m_q[p].size()), "rand_fill");
            reg_read(8'd5, W'(m_drop), "rand_drop_cnt");
            if (it % 4 == 3) drain();
        end
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_unicast();
        test_multicast();
        test_broadcast_drop();
        test_backpressure();
        test_drop_saturation();
        test_reset_midpacket();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
